// File: rtl/stacked_regfile_stack_pkg.sv
// Shared definitions for the stacked register file: command encoding and
// the sizing helper used for the level counter.
package stacked_regfile_stack_pkg;

  localparam int unsigned CMD_WIDTH = 2;

  typedef enum logic [CMD_WIDTH-1:0] {
    CMD_IDLE = 2'd0,
    CMD_PUSH = 2'd1,
    CMD_POP  = 2'd2
  } command_t;

  // Bits needed to index DEPTH frames; never narrower than one bit.
  function automatic int unsigned level_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stacked_regfile_frame.sv
// One NREGS x WIDTH register frame. It can be loaded from a full-frame copy
// (with masked registers cleared) and written through a single write port.
// A write in the same cycle as a load overrides the copied value.
module stacked_regfile_frame #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  parameter logic [NREGS-1:0] MASK = '1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [NREGS*WIDTH-1:0]     copy_data,
  input  logic                       we,
  input  logic [$clog2(NREGS)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [NREGS*WIDTH-1:0]     frame_data
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [WIDTH-1:0] regs [NREGS];

  // Register storage: copy-on-load with clear mask, then write port on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (load) begin
          regs[r] <= MASK[r] ? copy_data[r*WIDTH +: WIDTH] : '0;
        end
        if (we && (wr_addr == AW'(r))) begin
          regs[r] <= wr_data;
        end
      end
    end
  end

  // Flatten the frame for the parent's copy and read steering.
  always_comb begin
    frame_data = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      frame_data[r*WIDTH +: WIDTH] = regs[r];
    end
  end

endmodule

// File: rtl/stacked_regfile_stack.sv
// Stack of DEPTH register frames. Push copies the active frame one level up
// and makes it active; pop returns to the saved frame below. Two
// combinational read ports and one write port act on the active frame.
module stacked_regfile_stack
  import stacked_regfile_stack_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter logic [NREGS-1:0] MASK = '1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [CMD_WIDTH-1:0]              i_command,
  input  logic [$clog2(NREGS)-1:0]          i_rs1_addr,
  input  logic [$clog2(NREGS)-1:0]          i_rs2_addr,
  output logic [WIDTH-1:0]                  o_rs1_data,
  output logic [WIDTH-1:0]                  o_rs2_data,
  input  logic                              i_we,
  input  logic [$clog2(NREGS)-1:0]          i_rd_addr,
  input  logic [WIDTH-1:0]                  i_rd_data,
  output logic [level_width(DEPTH)-1:0]     o_level,
  output logic                              o_empty,
  output logic                              o_full,
  output logic                              o_overflow,
  output logic                              o_underflow
);

  localparam int unsigned LW = level_width(DEPTH);

  logic [LW-1:0]          level;
  logic [LW-1:0]          next_level;
  logic                   empty;
  logic                   full;
  logic                   push_req;
  logic                   pop_req;
  logic                   do_push;
  logic                   do_pop;
  logic                   wr_ok;
  logic [DEPTH-1:0]       load_vec;
  logic [DEPTH-1:0]       we_vec;
  logic [NREGS*WIDTH-1:0] frame_bus [DEPTH];
  logic [NREGS*WIDTH-1:0] active_frame;
  logic [WIDTH-1:0]       active_regs [NREGS];

  // Command decode; unknown encodings fall through as idle.
  always_comb begin
    empty    = (level == '0);
    full     = (level == LW'(DEPTH - 1));
    push_req = (i_command == CMD_PUSH);
    pop_req  = (i_command == CMD_POP);
    do_push  = push_req && !full;
    do_pop   = pop_req && !empty;
    wr_ok    = i_we && !((ZERO_REG != 0) && (i_rd_addr == '0));
  end

  // Level after this edge's command; writes target this frame.
  always_comb begin
    next_level = level;
    if (do_push) begin
      next_level = level + LW'(1);
    end else if (do_pop) begin
      next_level = level - LW'(1);
    end
  end

  // Steer the copy into the frame above and the write into the post-command frame.
  always_comb begin
    load_vec = '0;
    we_vec   = '0;
    for (int unsigned f = 0; f < DEPTH; f++) begin
      load_vec[f] = do_push && (next_level == LW'(f));
      we_vec[f]   = wr_ok && (next_level == LW'(f));
    end
  end

  // Level counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level <= '0;
    end else begin
      level <= next_level;
    end
  end

  // Registered one-cycle error pulses for rejected push/pop.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= push_req && full;
      o_underflow <= pop_req && empty;
    end
  end

  for (genvar f = 0; f < DEPTH; f++) begin : g_frame
    stacked_regfile_frame #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .MASK  (MASK)
    ) u_frame (
      .clk        (i_clk),
      .rst_n      (i_reset_n),
      .load       (load_vec[f]),
      .copy_data  (active_frame),
      .we         (we_vec[f]),
      .wr_addr    (i_rd_addr),
      .wr_data    (i_rd_data),
      .frame_data (frame_bus[f])
    );
  end

  // Select and unpack the active frame for the read muxes.
  always_comb begin
    active_frame = frame_bus[level];
    for (int unsigned r = 0; r < NREGS; r++) begin
      active_regs[r] = active_frame[r*WIDTH +: WIDTH];
    end
  end

  // Combinational read ports with optional hardwired zero register.
  always_comb begin
    o_rs1_data = active_regs[i_rs1_addr];
    o_rs2_data = active_regs[i_rs2_addr];
    if ((ZERO_REG != 0) && (i_rs1_addr == '0)) begin
      o_rs1_data = '0;
    end
    if ((ZERO_REG != 0) && (i_rs2_addr == '0)) begin
      o_rs2_data = '0;
    end
  end

  // Status derived from the level register.
  always_comb begin
    o_level = level;
    o_empty = empty;
    o_full  = full;
  end

endmodule

// File: doc/stacked_regfile_stack.md
Name: stacked_regfile_stack

Overview:
- Parametrised successor to the single-level regfile instance. Holds DEPTH stacked frames of NREGS registers, each WIDTH bits wide.
- Push saves the active frame and copies it into the next level. Pop discards the active frame and restores the one below.
- Provides two combinational read ports and one write port on the active frame, plus stack status and error pulses.
- Sits between the core's decode/writeback stage and the interrupt controller, which issues push/pop on trap entry/exit.

Parameters:
- WIDTH, 32, register width in bits.
- NREGS, 32, registers per frame (power of two, >=2).
- DEPTH, 4, number of stacked frames (power of two, >=2).
- MASK, all-ones (NREGS bits), bit i=0 means register i is cleared in the new frame on push and is never preserved.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes.

Ports:
- i_clk  in  1  dedicated clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_command  in  Command (2)  idle / push / pop, from shared package.
- i_rs1_addr  in  clog2(NREGS)  read port 1 address.
- i_rs2_addr  in  clog2(NREGS)  read port 2 address.
- o_rs1_data  out  WIDTH  active-frame register i_rs1_addr.
- o_rs2_data  out  WIDTH  active-frame register i_rs2_addr.
- i_we  in  1  write enable.
- i_rd_addr  in  clog2(NREGS)  write address.
- i_rd_data  in  WIDTH  write data.
- o_level  out  clog2(DEPTH)  index of the active frame (0 = bottom).
- o_empty  out  1  o_level == 0.
- o_full  out  1  o_level == DEPTH-1.
- o_overflow  out  1  one-cycle pulse: push rejected.
- o_underflow  out  1  one-cycle pulse: pop rejected.

Behaviour:
- Reset (async assert, sync release):
  - All registers of all frames = 0, level = 0.
  - o_overflow = o_underflow = 0; o_empty = 1, o_full = 0.
  - Reads return 0.
- Reads:
  - Combinational from the active frame (frame[level]).
  - No write-to-read bypass: a write is visible the cycle after it is accepted.
  - If ZERO_REG, address 0 returns 0 regardless of storage.
- Push (not full), at the clock edge:
  - level <= level+1.
  - frame[level+1][i] <= MASK[i] ? frame[level][i] : 0.
  - frame[level] is unchanged (saved).
- Pop (not empty), at the clock edge:
  - level <= level-1.
  - frame[level-1] becomes active with its saved contents.
  - The popped frame's contents are don't-care; the next push overwrites them fully.
- Write:
  - If i_we and the target is not (ZERO_REG and addr 0), write i_rd_data into the frame that is active AFTER this edge's command.
  - Push + write: the write lands in the new frame, overriding the copied value for i_rd_addr. The saved frame keeps its old value.
  - Pop + write: the write lands in the restored frame.
- Push when full:
  - Level and frames unchanged; o_overflow = 1 for exactly the next cycle.
  - A coincident write still goes to the current frame.
- Pop when empty:
  - Level and frames unchanged; o_underflow = 1 for the next cycle.
  - A coincident write still goes to frame 0.
- Command encodings outside push/pop are treated as idle.
- o_overflow/o_underflow are registered. o_empty, o_full and o_level derive from the level register.
- Reset asserted mid-push or mid-pop: state goes immediately to the reset values; no partial copy survives.

Decomposition:
- Shared package (existing veryl_stacked_regfile_RegFilePkg):
  - Command enum: idle, push, pop.
  - Add a helper constant for the level width function.
- One sub-module, stacked_regfile_frame:
  - One NREGS x WIDTH frame with load-from-copy, clear-mask, single write port, and full-frame output.
  - Instantiated DEPTH times.
- Top level owns the level counter, copy/write steering, read muxes and error flags.

Test Plan:
- Reset with i_reset_n=0 mid-run after writes -> all reads 0, o_level=0, o_empty=1, o_full=0, both error flags 0, asynchronously before the next edge.
- Write x5=0xDEAD_BEEF at level 0, then push -> o_level=1 and x5 reads 0xDEAD_BEEF. Then write x5=0x1234 and pop -> o_level=0, x5 reads 0xDEAD_BEEF.
- MASK=0xFFFF_FF00: write x3=7 and x9=9, then push -> in the new frame x3 reads 0 and x9 reads 9. Pop -> x3 reads 7.
- Push with simultaneous write x7=0xAA -> new frame x7=0xAA. After pop, x7 holds its pre-push value.
- Push DEPTH-1 times -> o_full=1. One more push -> o_overflow high for one cycle, o_level=DEPTH-1, contents unchanged. Pop DEPTH-1 times then pop again -> o_underflow pulse, o_level=0.
- ZERO_REG=1: write x0=0xFFFF_FFFF -> x0 reads 0 on both ports. Simultaneous reads rs1=x0 and rs2=x31 return 0 and the x31 value respectively.
